// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared state encoding for the FIFO read-side stream stage
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_skid_reg.sv
// rtl/fifo_skid_reg.sv - two-entry head/skid storage with load and shift controls
module fifo_skid_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  load_h,
    input  logic                  shift_h,
    input  logic                  load_s,
    output logic [DATA_WIDTH-1:0] h_data,
    output logic [DATA_WIDTH-1:0] s_data
);

    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] s_q, s_d;

    // Shift into head takes the old skid value, so a simultaneous load_s refills skid.
    always_comb begin
        h_d = h_q;
        s_d = s_q;
        if (load_h) begin
            h_d = din;
        end else if (shift_h) begin
            h_d = s_q;
        end
        if (load_s) begin
            s_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            s_q <= '0;
        end else begin
            h_q <= h_d;
            s_q <= s_d;
        end
    end

    assign h_data = h_q;
    assign s_data = s_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - converts FIFO rinc/rempty pops into a registered valid/ready stream
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    rd_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  pop_count_q, pop_count_d;
    logic                  take;
    logic                  load_h, shift_h, load_s;
    logic [DATA_WIDTH-1:0] s_data;

    // m_ready only reaches rinc (and only when full), never m_data.
    assign rinc    = ~rempty & ~flush & ((state_q != ST_TWO) | m_ready);
    assign m_valid = (state_q != ST_EMPTY);
    assign take    = m_valid & m_ready;

    always_comb begin
        state_d     = state_q;
        load_h      = 1'b0;
        shift_h     = 1'b0;
        load_s      = 1'b0;
        pop_count_d = pop_count_q + CNT_WIDTH'(take);
        case (state_q)
            ST_EMPTY: begin
                if (rinc) begin
                    load_h  = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (rinc && !take) begin
                    load_s  = 1'b1;
                    state_d = ST_TWO;
                end else if (rinc && take) begin
                    load_h  = 1'b1;
                end else if (take) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (take) begin
                    shift_h = 1'b1;
                    if (rinc) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= ST_EMPTY;
            pop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pop_count_q <= pop_count_d;
        end
    end

    fifo_skid_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk    (rclk),
        .rst_n  (rrst_n),
        .din    (rdata),
        .load_h (load_h),
        .shift_h(shift_h),
        .load_s (load_s),
        .h_data (m_data),
        .s_data (s_data)
    );

    assign occupancy = state_q;
    assign pop_count = pop_count_q;

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side output stage of the asynchronous FIFO, in the read clock domain, directly downstream of the read-pointer/empty-flag stage and the dual-port memory.
- Converts the FIFO's rinc/rempty pop interface into a registered valid/ready stream through a 2-entry skid buffer.
- Sustains one word per cycle with no combinational path from m_ready to m_data.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of the stream data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- rclk  input  1  read clock.
- rrst_n  input  1  read reset. Asynchronous, active-low.
- rempty  input  1  registered FIFO empty flag from the read-pointer stage.
- rdata  input  DATA_WIDTH  memory read data. Combinational from the current raddr, so it is valid in the same cycle.
- rinc  output  1  pop request to the read-pointer stage.
- flush  input  1  synchronous discard of buffered words.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream consumer ready.
- m_data  output  DATA_WIDTH  stream data, registered.
- occupancy  output  2  number of buffered words (0..2).
- pop_count  output  CNT_WIDTH  count of words accepted by the consumer.

Behaviour:
- Reset (rrst_n low, asynchronous):
  - occupancy=0, m_valid=0, m_data=0, pop_count=0.
  - Both buffer entries are cleared to 0.
  - rinc=0, because occupancy=0 is not sufficient; rinc also requires rempty=0, and rempty resets to 1.
- Storage: head register H drives m_data; skid register S holds the second word.
- Control states:
  - EMPTY: occupancy 0.
  - ONE: H valid.
  - TWO: H and S valid.
- m_valid = (state != EMPTY). occupancy is the state encoding: EMPTY=0, ONE=1, TWO=2.
- Handshake events:
  - pop = rinc. The word on rdata is captured at the rclk edge where rinc=1.
  - take = m_valid & m_ready.
- Pop request: rinc = ~rempty & ~flush & ((state != TWO) | m_ready).
  - rinc is combinational from registered rempty, registered state, flush and m_ready.
  - rinc is never asserted while rempty=1.
- Transitions and datapath:
  - EMPTY, pop: H<=rdata, go to ONE.
  - ONE, pop & ~take: S<=rdata, go to TWO.
  - ONE, pop & take: H<=rdata, stay in ONE.
  - ONE, ~pop & take: go to EMPTY.
  - ONE, no event: hold.
  - TWO, take & pop: H<=S, S<=rdata, stay in TWO.
  - TWO, take & ~pop: H<=S, go to ONE.
  - TWO, ~take: hold. pop cannot occur because rinc=0.
- Latency: a word leaves the FIFO memory in cycle N and appears on m_data with m_valid=1 in cycle N+1.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word is delivered per cycle.
- Ordering is strict FIFO; no word is dropped or duplicated except on flush.
- flush:
  - In the cycle flush=1, rinc is forced to 0.
  - At the clock edge the state goes to EMPTY and m_valid drops in the next cycle.
  - A take in the flush cycle still counts in pop_count.
  - Buffered words are lost. The FIFO read pointer does not rewind.
- pop_count increments by 1 on each take and wraps modulo 2^CNT_WIDTH with no saturation.
- m_data and m_valid do not change while m_valid=1 and m_ready=0.
- Reset mid-stream: asynchronous return to the reset values.
  - The read-pointer stage resets on the same rrst_n, so no in-flight word is lost in an inconsistent way.

Decomposition:
- Shared package: state enum {ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2}, used by this block and its assertions/bench.
- One natural sub-module: fifo_skid_reg, the 2-entry H/S storage with load/shift controls.
- State, rinc logic and pop_count stay in the top.

Test Plan:
- Reset, then rempty=1 for 10 cycles -> rinc=0, m_valid=0, occupancy=0, pop_count=0 throughout.
- FIFO holds 0x11,0x22,0x33 and m_ready=1 -> rinc high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first rinc; pop_count=3.
- m_ready=0 with FIFO holding 5 words -> exactly 2 pops; occupancy=2; rinc=0 afterwards; m_data holds 0x11 stable.
- Release m_ready=1 -> remaining words delivered in order, one per cycle; after the last word occupancy=0 and m_valid=0.
- occupancy=2, assert flush 1 cycle with m_ready=0 -> rinc=0 that cycle; next cycle occupancy=0 and m_valid=0; pop_count unchanged; the next pop delivers the 3rd FIFO word.
- pop_count preset to 0xFFFF (CNT_WIDTH=16) by 65535 takes, then 1 more take -> pop_count=0x0000.
- rrst_n pulsed low mid-stream at occupancy=2 -> immediately m_valid=0, occupancy=0, m_data=0.
